// File: rtl/aes_pkg.sv
// Shared types for the AES-256 CBC sequencers: FSM state encoding and the 128-bit block type.
package aes_pkg;

    localparam int BLK_W = 128;

    typedef logic [BLK_W-1:0] block_t;

    typedef enum logic [2:0] {
        NOIV  = 3'd0,
        RDY   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_e;

endpackage

// File: rtl/aes_chain_reg.sv
// CBC chaining register: IV load beats ciphertext load, nothing moves while en_i is low.
module aes_chain_reg (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en_i,
    input  logic         iv_load_i,
    input  logic [127:0] iv_i,
    input  logic         ct_load_i,
    input  logic [127:0] ct_i,
    output logic [127:0] chain_o
);
    import aes_pkg::*;

    block_t chain_q;
    block_t chain_d;

    always_comb begin
        chain_d = chain_q;
        if (iv_load_i) begin
            chain_d = iv_i;
        end else if (ct_load_i) begin
            chain_d = ct_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain_q <= '0;
        end else if (en_i) begin
            chain_q <= chain_d;
        end
    end

    assign chain_o = chain_q;

endmodule

// File: rtl/aes256_cbc_enc_seq.sv
// CBC encryption sequencer: one block in flight, p handshake -> core request 1 cycle, ct strobe -> cvalid 1 cycle.
// All outputs are registered; readies are derived from the next state so they line up with the state register.
module aes256_cbc_enc_seq #(
    parameter int BLK_W = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable_i,
    input  logic [BLK_W-1:0] iv_i,
    input  logic             ivalid_i,
    output logic             iv_ready_o,
    input  logic [BLK_W-1:0] p_i,
    input  logic             pvalid_i,
    output logic             p_ready_o,
    output logic [BLK_W-1:0] core_blk_o,
    output logic             core_valid_o,
    input  logic             core_ready_i,
    input  logic [BLK_W-1:0] core_ct_i,
    input  logic             core_ct_valid_i,
    output logic [BLK_W-1:0] c_o,
    output logic             cvalid_o,
    input  logic             c_ready_i,
    output logic [CNT_W-1:0] blk_cnt_o,
    output logic             busy_o
);
    import aes_pkg::*;

    state_e           state_q, state_d;
    logic             iv_ready_q, iv_ready_d;
    logic             p_ready_q, p_ready_d;
    logic             core_valid_q, core_valid_d;
    logic             cvalid_q, cvalid_d;
    logic             busy_q, busy_d;
    logic [BLK_W-1:0] core_blk_q, core_blk_d;
    logic [BLK_W-1:0] c_q, c_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0] chain;

    logic iv_hs, p_hs, issue_hs, ct_hs, out_hs;

    assign iv_hs    = enable_i & ivalid_i & iv_ready_q;
    assign p_hs     = enable_i & pvalid_i & p_ready_q;
    assign issue_hs = enable_i & core_valid_q & core_ready_i;
    assign ct_hs    = enable_i & core_ct_valid_i & (state_q == WAIT);
    assign out_hs   = enable_i & cvalid_q & c_ready_i;

    aes_chain_reg u_chain (
        .clk       (clk),
        .resetn    (resetn),
        .en_i      (enable_i),
        .iv_load_i (iv_hs),
        .iv_i      (iv_i),
        .ct_load_i (ct_hs),
        .ct_i      (core_ct_i),
        .chain_o   (chain)
    );

    always_comb begin
        state_d    = state_q;
        core_blk_d = core_blk_q;
        c_d        = c_q;
        blk_cnt_d  = blk_cnt_q;

        if (iv_hs) begin
            blk_cnt_d = '0;
        end

        case (state_q)
            NOIV: begin
                if (iv_hs) begin
                    state_d = RDY;
                end
            end
            RDY: begin
                // A same-cycle IV wins: the block is chained onto the new IV, not the stale chain.
                if (p_hs) begin
                    core_blk_d = p_i ^ (iv_hs ? iv_i : chain);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_hs) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ct_hs) begin
                    c_d     = core_ct_i;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_hs) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d   = RDY;
                end
            end
            default: state_d = NOIV;
        endcase

        iv_ready_d   = (state_d == NOIV) || (state_d == RDY);
        p_ready_d    = (state_d == RDY);
        core_valid_d = (state_d == ISSUE);
        cvalid_d     = (state_d == OUT);
        busy_d       = (state_d == ISSUE) || (state_d == WAIT) || (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= NOIV;
            iv_ready_q   <= 1'b0;
            p_ready_q    <= 1'b0;
            core_valid_q <= 1'b0;
            cvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            core_blk_q   <= '0;
            c_q          <= '0;
            blk_cnt_q    <= '0;
        end else if (enable_i) begin
            state_q      <= state_d;
            iv_ready_q   <= iv_ready_d;
            p_ready_q    <= p_ready_d;
            core_valid_q <= core_valid_d;
            cvalid_q     <= cvalid_d;
            busy_q       <= busy_d;
            core_blk_q   <= core_blk_d;
            c_q          <= c_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

    assign iv_ready_o   = iv_ready_q;
    assign p_ready_o    = p_ready_q;
    assign core_blk_o   = core_blk_q;
    assign core_valid_o = core_valid_q;
    assign c_o          = c_q;
    assign cvalid_o     = cvalid_q;
    assign blk_cnt_o    = blk_cnt_q;
    assign busy_o       = busy_q;

    // The core needs at least one cycle, so a reply alongside the issue handshake is a protocol error.
    a_no_ct_on_issue: assert property (@(posedge clk) disable iff (!resetn)
        issue_hs |-> !core_ct_valid_i);

    // NOIV is exempt: a reset mid-operation can leave the core's reply still in flight.
    a_ct_only_in_wait: assert property (@(posedge clk) disable iff (!resetn)
        (enable_i && (state_q == RDY || state_q == ISSUE || state_q == OUT)) |-> !core_ct_valid_i);

endmodule

// File: tb/tb_aes256_cbc_enc_seq.sv
// Directed bench for the CBC encryption sequencer, with a second 2-bit-counter instance for wrap.
module tb_aes256_cbc_enc_seq;

    localparam logic [127:0] IV1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3     = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] C1     = 128'hf58c4c04d6e5f1ba779eabfb5f7bfbd6;
    localparam logic [127:0] C2     = 128'h9cfc4e967edb808d679f777bc6702c7d;
    localparam logic [127:0] C3     = 128'h39f23369a9d9bacfa530e26304231461;
    localparam logic [127:0] E1     = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] E2     = 128'h5ba1c653c8e65d26e929c4571ad47587;
    localparam logic [127:0] E3     = 128'hac3452d0dd87649c8264b662dc7a7e92;
    localparam logic [127:0] IV2    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PONES  = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] ESIM   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] JUNK_I = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam logic [127:0] JUNK_P = 128'h0123456789abcdef0123456789abcdef;

    logic         clk;
    logic         resetn;
    logic         enable_i;
    logic [127:0] iv_i;
    logic         ivalid_i;
    logic [127:0] p_i;
    logic         pvalid_i;
    logic         core_ready_i;
    logic [127:0] core_ct_i;
    logic         core_ct_valid_i;
    logic         c_ready_i;

    logic         iv_ready_o, p_ready_o, core_valid_o, cvalid_o, busy_o;
    logic [127:0] core_blk_o, c_o;
    logic [15:0]  blk_cnt_o;

    logic         w_iv_ready, w_p_ready, w_core_valid, w_cvalid, w_busy;
    logic [127:0] w_core_blk, w_c;
    logic [1:0]   w_blk_cnt;

    int tot;
    int pass;

    aes256_cbc_enc_seq #(.BLK_W(128), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .enable_i(enable_i),
        .iv_i(iv_i), .ivalid_i(ivalid_i), .iv_ready_o(iv_ready_o),
        .p_i(p_i), .pvalid_i(pvalid_i), .p_ready_o(p_ready_o),
        .core_blk_o(core_blk_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_ct_i(core_ct_i), .core_ct_valid_i(core_ct_valid_i),
        .c_o(c_o), .cvalid_o(cvalid_o), .c_ready_i(c_ready_i),
        .blk_cnt_o(blk_cnt_o), .busy_o(busy_o)
    );

    aes256_cbc_enc_seq #(.BLK_W(128), .CNT_W(2)) dut_w (
        .clk(clk), .resetn(resetn), .enable_i(enable_i),
        .iv_i(iv_i), .ivalid_i(ivalid_i), .iv_ready_o(w_iv_ready),
        .p_i(p_i), .pvalid_i(pvalid_i), .p_ready_o(w_p_ready),
        .core_blk_o(w_core_blk), .core_valid_o(w_core_valid), .core_ready_i(core_ready_i),
        .core_ct_i(core_ct_i), .core_ct_valid_i(core_ct_valid_i),
        .c_o(w_c), .cvalid_o(w_cvalid), .c_ready_i(c_ready_i),
        .blk_cnt_o(w_blk_cnt), .busy_o(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drives one block through RDY -> ISSUE -> WAIT -> OUT -> RDY with a zero-stall core and sink.
    task automatic push_block(input logic [127:0] p, input logic [127:0] ct);
        int n;
        n = 0;
        while (p_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tot++;
            $display("FAIL push_wait_p_ready: got %b required 1 within 20 cycles", p_ready_o);
        end
        pvalid_i = 1'b1; p_i = p;
        @(negedge clk);
        pvalid_i = 1'b0;
        core_ready_i = 1'b1;
        @(negedge clk);
        core_ready_i = 1'b0;
        core_ct_i = ct; core_ct_valid_i = 1'b1;
        @(negedge clk);
        core_ct_valid_i = 1'b0;
        c_ready_i = 1'b1;
        @(negedge clk);
        c_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        tot++; if (iv_ready_o !== 1'b0) $display("FAIL rst_iv_ready: got %b required 0", iv_ready_o); else pass++;
        tot++; if (p_ready_o !== 1'b0) $display("FAIL rst_p_ready: got %b required 0", p_ready_o); else pass++;
        tot++; if (core_valid_o !== 1'b0) $display("FAIL rst_core_valid: got %b required 0", core_valid_o); else pass++;
        tot++; if (core_blk_o !== 128'h0) $display("FAIL rst_core_blk: got %h required 0", core_blk_o); else pass++;
        tot++; if (c_o !== 128'h0) $display("FAIL rst_c: got %h required 0", c_o); else pass++;
        tot++; if (cvalid_o !== 1'b0) $display("FAIL rst_cvalid: got %b required 0", cvalid_o); else pass++;
        tot++; if (blk_cnt_o !== 16'd0) $display("FAIL rst_blk_cnt: got %0d required 0", blk_cnt_o); else pass++;
        tot++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy_o); else pass++;
        resetn = 1'b1;
        @(negedge clk);
        tot++; if (iv_ready_o !== 1'b1) $display("FAIL noiv_iv_ready: got %b required 1", iv_ready_o); else pass++;
        tot++; if (p_ready_o !== 1'b0) $display("FAIL noiv_p_ready: got %b required 0", p_ready_o); else pass++;
    endtask

    task automatic test_basic();
        ivalid_i = 1'b1; iv_i = IV1;
        @(negedge clk);
        ivalid_i = 1'b0;
        tot++; if (p_ready_o !== 1'b1) $display("FAIL rdy_p_ready: got %b required 1", p_ready_o); else pass++;
        pvalid_i = 1'b1; p_i = P1;
        @(negedge clk);
        pvalid_i = 1'b0;
        tot++; if (core_valid_o !== 1'b1) $display("FAIL p1_core_valid: got %b required 1", core_valid_o); else pass++;
        tot++; if (core_blk_o !== E1) $display("FAIL p1_core_blk: got %h required %h", core_blk_o, E1); else pass++;
        tot++; if (busy_o !== 1'b1) $display("FAIL p1_busy: got %b required 1", busy_o); else pass++;
        tot++; if (p_ready_o !== 1'b0) $display("FAIL p1_p_ready: got %b required 0", p_ready_o); else pass++;
        core_ready_i = 1'b1;
        @(negedge clk);
        core_ready_i = 1'b0;
        tot++; if (core_valid_o !== 1'b0) $display("FAIL p1_wait_core_valid: got %b required 0", core_valid_o); else pass++;
        core_ct_i = C1; core_ct_valid_i = 1'b1;
        @(negedge clk);
        core_ct_valid_i = 1'b0;
        tot++; if (cvalid_o !== 1'b1) $display("FAIL p1_cvalid: got %b required 1", cvalid_o); else pass++;
        tot++; if (c_o !== C1) $display("FAIL p1_c: got %h required %h", c_o, C1); else pass++;
        c_ready_i = 1'b1;
        @(negedge clk);
        c_ready_i = 1'b0;
        tot++; if (blk_cnt_o !== 16'd1) $display("FAIL p1_blk_cnt: got %0d required 1", blk_cnt_o); else pass++;
        tot++; if (cvalid_o !== 1'b0) $display("FAIL p1_cvalid_drop: got %b required 0", cvalid_o); else pass++;
        tot++; if (p_ready_o !== 1'b1) $display("FAIL p1_p_ready_back: got %b required 1", p_ready_o); else pass++;
        pvalid_i = 1'b1; p_i = P2;
        @(negedge clk);
        pvalid_i = 1'b0;
        tot++; if (core_blk_o !== E2) $display("FAIL p2_core_blk: got %h required %h", core_blk_o, E2); else pass++;
        core_ready_i = 1'b1;
        @(negedge clk);
        core_ready_i = 1'b0;
        core_ct_i = C2; core_ct_valid_i = 1'b1;
        @(negedge clk);
        core_ct_valid_i = 1'b0;
        tot++; if (c_o !== C2) $display("FAIL p2_c: got %h required %h", c_o, C2); else pass++;
    endtask

    task automatic test_out_stall();
        for (int i = 0; i < 10; i++) begin
            ivalid_i = (i % 2 == 0); iv_i = JUNK_I;
            pvalid_i = 1'b1; p_i = JUNK_P;
            @(negedge clk);
            tot++; if (c_o !== C2 || cvalid_o !== 1'b1) $display("FAIL stall_c: got %h/%b required %h/1", c_o, cvalid_o, C2); else pass++;
            tot++; if (iv_ready_o !== 1'b0 || p_ready_o !== 1'b0) $display("FAIL stall_readies: got %b%b required 00", iv_ready_o, p_ready_o); else pass++;
        end
        ivalid_i = 1'b0; pvalid_i = 1'b0;
        tot++; if (blk_cnt_o !== 16'd1) $display("FAIL stall_blk_cnt: got %0d required 1", blk_cnt_o); else pass++;
        c_ready_i = 1'b1;
        @(negedge clk);
        c_ready_i = 1'b0;
        tot++; if (blk_cnt_o !== 16'd2) $display("FAIL p2_blk_cnt: got %0d required 2", blk_cnt_o); else pass++;
        pvalid_i = 1'b1; p_i = P3;
        @(negedge clk);
        pvalid_i = 1'b0;
        tot++; if (core_blk_o !== E3) $display("FAIL p3_chain_kept: got %h required %h", core_blk_o, E3); else pass++;
        core_ready_i = 1'b1;
        @(negedge clk);
        core_ready_i = 1'b0;
        core_ct_i = C3; core_ct_valid_i = 1'b1;
        @(negedge clk);
        core_ct_valid_i = 1'b0;
        c_ready_i = 1'b1;
        @(negedge clk);
        c_ready_i = 1'b0;
        tot++; if (blk_cnt_o !== 16'd3) $display("FAIL p3_blk_cnt: got %0d required 3", blk_cnt_o); else pass++;
    endtask

    task automatic test_simul_iv_p();
        ivalid_i = 1'b1; iv_i = IV2;
        pvalid_i = 1'b1; p_i = PONES;
        @(negedge clk);
        ivalid_i = 1'b0; pvalid_i = 1'b0;
        tot++; if (core_blk_o !== ESIM) $display("FAIL simul_core_blk: got %h required %h", core_blk_o, ESIM); else pass++;
        tot++; if (blk_cnt_o !== 16'd0) $display("FAIL simul_blk_cnt: got %0d required 0", blk_cnt_o); else pass++;
        tot++; if (core_valid_o !== 1'b1) $display("FAIL simul_core_valid: got %b required 1", core_valid_o); else pass++;
    endtask

    task automatic test_enable();
        enable_i = 1'b0; core_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tot++; if (core_valid_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL en_low_hold: got valid=%b busy=%b required 1/1", core_valid_o, busy_o); else pass++;
        end
        enable_i = 1'b1;
        @(negedge clk);
        core_ready_i = 1'b0;
        tot++; if (core_valid_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL en_issue_done: got valid=%b busy=%b required 0/1", core_valid_o, busy_o); else pass++;
        core_ct_i = C1; core_ct_valid_i = 1'b1;
        @(negedge clk);
        core_ct_valid_i = 1'b0;
        c_ready_i = 1'b1;
        @(negedge clk);
        c_ready_i = 1'b0;
        tot++; if (blk_cnt_o !== 16'd1) $display("FAIL en_blk_cnt: got %0d required 1", blk_cnt_o); else pass++;
    endtask

    task automatic test_reset_mid();
        pvalid_i = 1'b1; p_i = P1;
        @(negedge clk);
        pvalid_i = 1'b0; core_ready_i = 1'b1;
        @(negedge clk);
        core_ready_i = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tot++; if ({iv_ready_o, p_ready_o, core_valid_o, cvalid_o, busy_o} !== 5'b0) $display("FAIL mid_rst_flags: got %b required 00000", {iv_ready_o, p_ready_o, core_valid_o, cvalid_o, busy_o}); else pass++;
        tot++; if (core_blk_o !== 128'h0 || c_o !== 128'h0) $display("FAIL mid_rst_data: got %h/%h required 0/0", core_blk_o, c_o); else pass++;
        tot++; if (blk_cnt_o !== 16'd0) $display("FAIL mid_rst_blk_cnt: got %0d required 0", blk_cnt_o); else pass++;
        core_ct_i = C3; core_ct_valid_i = 1'b1;
        @(negedge clk);
        core_ct_valid_i = 1'b0;
        tot++; if (cvalid_o !== 1'b0 || c_o !== 128'h0) $display("FAIL late_ct_ignored: got %b/%h required 0/0", cvalid_o, c_o); else pass++;
        tot++; if (iv_ready_o !== 1'b1 || p_ready_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL mid_rst_noiv: got iv=%b p=%b busy=%b required 1/0/0", iv_ready_o, p_ready_o, busy_o); else pass++;
        pvalid_i = 1'b1; p_i = P2;
        repeat (3) @(negedge clk);
        pvalid_i = 1'b0;
        tot++; if (p_ready_o !== 1'b0 || core_valid_o !== 1'b0) $display("FAIL noiv_p_blocked: got p_ready=%b core_valid=%b required 0/0", p_ready_o, core_valid_o); else pass++;
    endtask

    task automatic test_cnt_wrap();
        ivalid_i = 1'b1; iv_i = IV1;
        @(negedge clk);
        ivalid_i = 1'b0;
        push_block(P1, C1);
        push_block(P2, C2);
        push_block(P3, C3);
        push_block(P1, C2);
        tot++; if (w_blk_cnt !== 2'd0) $display("FAIL wrap_cnt4: got %0d required 0", w_blk_cnt); else pass++;
        push_block(P2, C3);
        tot++; if (w_blk_cnt !== 2'd1) $display("FAIL wrap_cnt5: got %0d required 1", w_blk_cnt); else pass++;
        tot++; if (blk_cnt_o !== 16'd5) $display("FAIL wide_cnt5: got %0d required 5", blk_cnt_o); else pass++;
    endtask

    initial begin
        tot = 0; pass = 0;
        resetn = 1'b0; enable_i = 1'b1;
        iv_i = '0; ivalid_i = 1'b0; p_i = '0; pvalid_i = 1'b0;
        core_ready_i = 1'b0; core_ct_i = '0; core_ct_valid_i = 1'b0; c_ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_out_stall();
        test_simul_iv_p();
        test_enable();
        test_reset_mid();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
